// File: rtl/credit_tx.sv
// credit_tx: transmit side of a credit-based link into a remote FIFO.
// Producer words are taken through a valid/ready handshake into a 2-entry
// in-order buffer. The head word is pushed to the remote FIFO only while a
// credit is held. Each crd_ret pulse from the far side returns one credit.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module credit_tx #(
  parameter int ID    = 0,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [`DATA_WIDTH:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [`DATA_WIDTH:0] tx_data,
  output logic                 tx_enq,
  input  logic                 crd_ret,
  output logic [2:0]           credits,
  output logic                 idle,
  output logic                 err
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  // ID only tags the instance; it has no effect on behaviour.
  logic unused_id;
  assign unused_id = (ID != 0);

  logic [1:0]           cnt_q, cnt_d;
  logic [`DATA_WIDTH:0] buf0_q, buf0_d;
  logic [`DATA_WIDTH:0] buf1_q, buf1_d;
  logic [2:0]           crd_q, crd_d;
  logic                 err_q, err_d;

  logic push, pop;

  // Handshake and send decisions come from registered state only, so there
  // is no combinational path from src_valid or crd_ret to any output.
  assign src_ready = (cnt_q != 2'd2);
  assign tx_enq    = (cnt_q != 2'd0) && (crd_q != 3'd0);
  assign tx_data   = buf0_q;
  assign credits   = crd_q;
  assign idle      = (cnt_q == 2'd0) && (crd_q == DEPTH_C);
  assign err       = err_q;

  assign push = src_valid && src_ready;
  assign pop  = tx_enq;

  // Next state of the local buffer: entry 0 is always the head.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = src_data;
        else               buf1_d = src_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        buf1_d = '0;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the new word goes behind whatever remains.
        if (cnt_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = src_data;
        end else begin
          buf0_d = src_data;
        end
      end
      default: ;
    endcase
  end

  // Next credit count; a return with nothing outstanding is flagged, not counted.
  always_comb begin
    crd_d = crd_q;
    err_d = err_q;
    if (pop && !crd_ret) begin
      crd_d = crd_q - 3'd1;
    end else if (!pop && crd_ret) begin
      if (crd_q == DEPTH_C) err_d = 1'b1;
      else                  crd_d = crd_q + 3'd1;
    end
  end

  // State registers; reset drops buffered words and restores full credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
      crd_q  <= DEPTH_C;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      crd_q  <= crd_d;
      err_q  <= err_d;
    end
  end

endmodule
